// File: rtl/rat_call_stack.sv
// -----------------------------------------------------------------------------
// rat_call_stack
//
// Hardware return stack for the RAT MCU. It is a LIFO of WIDTH-bit entries,
// DEPTH deep. The control unit pushes PC_COUNT on CALL or interrupt entry and
// pops on RET/RETI. TOS feeds the program counter's FROM_STACK input.
//
// Parameters
//   WIDTH  bits per entry (>= 1)
//   DEPTH  number of entries (power of two, >= 2)
//   PTR_W  derived index width; leave at its default
//
// Ports
//   clk      rising-edge clock
//   RESET_N  asynchronous active-low reset of COUNT and status
//   CLR      synchronous clear of stack and status (highest priority)
//   PUSH     push DIN this cycle
//   POP      pop the top entry this cycle
//   ERR_CLR  synchronous clear of OVF/UNF (a new error in the same cycle wins)
//   DIN      data to push
//   TOS      top of stack, 0 when empty; depends only on registered state
//   COUNT    number of valid entries, 0..DEPTH
//   EMPTY    COUNT == 0
//   FULL     COUNT == DEPTH
//   OVF      sticky: push attempted while full without a pop
//   UNF      sticky: pop attempted while empty
//   HWM      maximum COUNT reached since reset/CLR
// -----------------------------------------------------------------------------
module rat_call_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic             CLR,
    input  logic             PUSH,
    input  logic             POP,
    input  logic             ERR_CLR,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] TOS,
    output logic [PTR_W:0]   COUNT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             OVF,
    output logic             UNF,
    output logic [PTR_W:0]   HWM
);

    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

    // Storage is deliberately not reset: COUNT alone decides what is valid.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W:0]   count_reg, count_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic [PTR_W:0]   hwm_reg, hwm_next;

    logic             is_empty;
    logic             is_full;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_addr;
    logic             wr_en;
    logic             ovf_set;
    logic             unf_set;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == DEPTH_C);

    // When full the low PTR_W bits of COUNT are zero, so the modular
    // subtraction lands on DEPTH-1, which is exactly the top entry.
    assign top_idx = count_reg[PTR_W-1:0] - IDX_ONE;

    // Push+pop on a non-empty stack replaces the top in place; every other
    // write goes to the first free slot (slot 0 when empty).
    assign wr_addr = (PUSH && POP && !is_empty) ? top_idx : count_reg[PTR_W-1:0];
    assign wr_en   = !CLR && PUSH && (POP || !is_full);

    assign ovf_set = PUSH && !POP && is_full;
    // A pop on an empty stack is an underflow even when paired with a push.
    assign unf_set = POP && is_empty;

    always_comb begin
        count_next = count_reg;
        if (CLR) begin
            count_next = '0;
        end else if (PUSH && !POP) begin
            if (!is_full) begin
                count_next = count_reg + CNT_ONE;
            end
        end else if (POP && !PUSH) begin
            if (!is_empty) begin
                count_next = count_reg - CNT_ONE;
            end
        end else if (PUSH && POP && is_empty) begin
            count_next = CNT_ONE;
        end
    end

    always_comb begin
        ovf_next = ovf_reg;
        unf_next = unf_reg;
        hwm_next = hwm_reg;
        if (CLR) begin
            ovf_next = 1'b0;
            unf_next = 1'b0;
            hwm_next = '0;
        end else begin
            // Set wins over ERR_CLR in the same cycle.
            ovf_next = ovf_set || (ovf_reg && !ERR_CLR);
            unf_next = unf_set || (unf_reg && !ERR_CLR);
            hwm_next = (count_next > hwm_reg) ? count_next : hwm_reg;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            hwm_reg   <= '0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
            hwm_reg   <= hwm_next;
        end
    end

    // One write-enabled register per entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == PTR_W'(gi))) begin
                    mem[gi] <= DIN;
                end
            end
        end
    endgenerate

    assign TOS   = is_empty ? '0 : mem[top_idx];
    assign COUNT = count_reg;
    assign EMPTY = is_empty;
    assign FULL  = is_full;
    assign OVF   = ovf_reg;
    assign UNF   = unf_reg;
    assign HWM   = hwm_reg;

endmodule
